// File: rtl/soc_system_adc_cmd_out.sv
// Avalon-MM write-side command PIO: host writes go into a small FIFO that
// drains onto a valid/ready stream toward the ADC controller.
module soc_system_adc_cmd_out #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic              chipselect,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              irq
);

  localparam int PTR_W = $clog2(DEPTH);

  // Stream handshake: a word transfers on any rising edge where out_valid and
  // out_ready are both high; out_data holds steady while valid waits on ready.

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              irq_en;

  logic        wr;
  logic        push_req;
  logic        ctrl_wr;
  logic        flush;
  logic        pop;
  logic        full;
  logic        empty;
  logic        push_ok;
  logic        drop;
  logic [31:0] status_word;
  logic [31:0] rd_mux;

  assign wr       = chipselect & ~write_n;
  assign push_req = wr && (address == 2'd0);
  assign ctrl_wr  = wr && (address == 2'd2);
  assign flush    = ctrl_wr && writedata[2];
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign out_valid = ~empty;
  assign out_data  = mem[rd_ptr];
  assign pop      = out_valid & out_ready;
  // A pop on the same edge frees the slot, so a push into a full FIFO is kept.
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    status_word = '0;
    status_word[CNT_W-1:0] = count;
    status_word[8]  = empty;
    status_word[9]  = full;
    status_word[10] = overflow;
    status_word[11] = irq_en;
  end

  always_comb begin
    rd_mux = '0;
    if (chipselect) begin
      case (address)
        2'd1:    rd_mux = status_word;
        2'd2:    rd_mux = {30'd0, irq_en, 1'b0};
        default: rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      irq_en   <= 1'b0;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
      irq      <= overflow & irq_en;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) begin
          mem[wr_ptr] <= writedata[DATA_W-1:0];
          wr_ptr      <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        if (push_ok && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push_ok) count <= count - CNT_W'(1);
      end
      // Set takes priority over a write-1-to-clear on the same edge.
      if (drop)                         overflow <= 1'b1;
      else if (ctrl_wr && writedata[0]) overflow <= 1'b0;
      if (ctrl_wr) irq_en <= writedata[1];
    end
  end

endmodule
